// File: rtl/pipelined_control_unit.sv
// Instruction decode feeding a PIPE_DEPTH-stage control pipeline with load-use interlock
// and a post-transfer flush window. Define CTRL_ILLEGAL_TRAP_EN to add the illegal_inst trap.
module pipelined_control_unit #(
  parameter int unsigned PIPE_DEPTH   = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ALU_OP_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [6:0]          in_opcode,
  input  logic [3:0]          in_func,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic                stall,
  input  logic                redirect,
  output logic                in_ready,
  output logic                hazard,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                illegal_inst,
`endif
  output logic                ex_valid,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_reg_reg,
  output logic                ex_mem_rd,
  output logic                ex_mem_wr,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                wb_valid,
  output logic                wb_en,
  output logic [4:0]          wb_rd
);

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       jump;
    logic       reg_reg;
    logic       mem_rd;
    logic       mem_wr;
    logic       wb_en;
    logic [3:0] alu;
    logic [4:0] rd;
  } ctrl_t;

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       started_q;
  ctrl_t      dec;
  ctrl_t      stage_q [PIPE_DEPTH];
  logic       legal, uses_rs2, load_dep, open_slot, accept, transfer;

  assign legal    = (in_opcode[1:0] == 2'b11);
  assign uses_rs2 = legal && ((in_opcode[5:4] == 2'b11) ||
                    ((in_opcode[5:4] == 2'b10) && (!in_opcode[6] || (in_opcode[3:2] == 2'b00))));

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    if (legal) begin
      dec.rd = in_rd;
      case (in_opcode[5:4])
        2'b00: begin
          dec.mem_rd = 1'b1;
          dec.wb_en  = 1'b1;
          dec.alu    = 4'b0001;
        end
        2'b01: begin
          dec.wb_en = 1'b1;
          if (in_opcode[2]) dec.alu = 4'b1101;
          else begin
            case (in_func[2:0])
              3'b000:  dec.alu = 4'b0001;
              3'b001:  dec.alu = 4'b0110;
              3'b010:  dec.alu = 4'b1010;
              3'b011:  dec.alu = 4'b1011;
              3'b100:  dec.alu = 4'b0011;
              3'b101:  dec.alu = in_func[3] ? 4'b1001 : 4'b0111;
              3'b110:  dec.alu = 4'b0100;
              default: dec.alu = 4'b0101;
            endcase
          end
        end
        2'b10: begin
          if (!in_opcode[6]) begin
            dec.mem_wr = 1'b1;
            dec.alu    = 4'b0001;
          end else if (in_opcode[3]) begin
            dec.jump    = 1'b1;
            dec.reg_reg = 1'b1;
            dec.wb_en   = 1'b1;
            dec.alu     = 4'b0001;
          end else if (in_opcode[2]) begin
            dec.jump  = 1'b1;
            dec.wb_en = 1'b1;
            dec.alu   = 4'b0001;
          end else begin
            dec.branch = 1'b1;
            case (in_func[2:1])
              2'b00:   dec.alu = 4'b0010;
              2'b10:   dec.alu = 4'b1010;
              2'b11:   dec.alu = 4'b1011;
              default: dec.alu = 4'b0000;
            endcase
          end
        end
        default: begin
          dec.reg_reg = 1'b1;
          dec.wb_en   = 1'b1;
          case (in_func)
            4'b0000: dec.alu = 4'b0001;
            4'b1000: dec.alu = 4'b0010;
            4'b0001: dec.alu = 4'b0110;
            4'b0010: dec.alu = 4'b1010;
            4'b0011: dec.alu = 4'b1011;
            4'b0100: dec.alu = 4'b0011;
            4'b0101: dec.alu = 4'b0111;
            4'b1101: dec.alu = 4'b1001;
            4'b0110: dec.alu = 4'b0100;
            4'b0111: dec.alu = 4'b0101;
            default: dec.alu = 4'b0000;
          endcase
        end
      endcase
    end
    if (dec.rd == '0) dec.wb_en = 1'b0;
  end

  // A load in EX blocks a consumer of its destination for one slot.
  assign load_dep  = in_valid && stage_q[0].valid && stage_q[0].mem_rd && (stage_q[0].rd != '0) &&
                     ((legal && (stage_q[0].rd == in_rs1)) || (uses_rs2 && (stage_q[0].rd == in_rs2)));
  assign open_slot = started_q && (state_q == RUN) && !redirect && !stall;
  assign hazard    = open_slot && load_dep;
  assign in_ready  = open_slot && !load_dep;
  assign accept    = in_valid && in_ready;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign transfer = accept && (dec.jump || !legal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 illegal_inst <= 1'b0;
    else if (accept && !legal)  illegal_inst <= 1'b1;
  end
`else
  assign transfer = accept && dec.jump;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redirect || ((state_q == RUN) && transfer)) begin
      state_d = FLUSH;
      cnt_d   = FLUSH_LOAD;
    end else if ((state_q == FLUSH) && !stall) begin
      if (cnt_q == 2'd1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) stage_q[k] <= '0;
    end else if (!stall) begin
      stage_q[0] <= accept ? dec : '0;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign ex_valid   = stage_q[0].valid;
  assign ex_branch  = stage_q[0].branch;
  assign ex_jump    = stage_q[0].jump;
  assign ex_reg_reg = stage_q[0].reg_reg;
  assign ex_mem_rd  = stage_q[0].mem_rd;
  assign ex_mem_wr  = stage_q[0].mem_wr;
  assign ex_alu_op  = ALU_OP_W'(stage_q[0].alu);
  assign wb_valid   = stage_q[PIPE_DEPTH-1].valid;
  assign wb_en      = stage_q[PIPE_DEPTH-1].wb_en;
  assign wb_rd      = stage_q[PIPE_DEPTH-1].rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: decode vector table, directed multi-cycle sequences,
// and randomized traffic checked against a cycle-level reference model.
module tb_pipelined_control_unit;

  localparam int unsigned PD = 3;
  localparam int unsigned FC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] in_opcode = '0;
  logic [3:0] in_func = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic       stall = 1'b0, redirect = 1'b0;
  logic       in_ready, hazard;
  logic       ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr;
  logic [3:0] ex_alu_op;
  logic       wb_valid, wb_en;
  logic [4:0] wb_rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_inst;
`endif

  pipelined_control_unit #(.PIPE_DEPTH(PD), .FLUSH_CYCLES(FC), .ALU_OP_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode), .in_func(in_func),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .stall(stall), .redirect(redirect),
    .in_ready(in_ready), .hazard(hazard),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_inst(illegal_inst),
`endif
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_reg_reg(ex_reg_reg),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_alu_op(ex_alu_op),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       jump;
    logic       reg_reg;
    logic       mem_rd;
    logic       mem_wr;
    logic       wb_en;
    logic [3:0] alu;
    logic [4:0] rd;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [3:0] fn;
    logic [4:0] rd;
    logic [9:0] ex;   // valid,branch,jump,reg_reg,mem_rd,mem_wr,alu[3:0]
  } vec_t;

  // ALU code lookups straight from the instruction-class tables
  logic [3:0] imm_alu [8]  = '{4'h1, 4'h6, 4'hA, 4'hB, 4'h3, 4'h7, 4'h4, 4'h5};
  logic [3:0] br_alu  [4]  = '{4'h2, 4'h0, 4'hA, 4'hB};
  logic [3:0] rr_alu  [16] = '{4'h1, 4'h6, 4'hA, 4'hB, 4'h3, 4'h7, 4'h4, 4'h5,
                               4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0};
  logic [6:0] op_pool [8]  = '{7'b0110011, 7'b0010011, 7'b0010111, 7'b0000011,
                               7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        m_pipe [PD];
  int unsigned m_left;
  bit          m_started;
  logic        s_ready, s_hazard;
  vec_t        vecs [19];
  int unsigned tries, zeros;
  bit          seen;
  logic [9:0]  snap_ex;
  logic [6:0]  snap_wb;
  logic [6:0]  r_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_dec(input logic [6:0] op, input logic [3:0] fn, input logic [4:0] rd);
    exp_t e;
    e = '0;
    e.valid = 1'b1;
    if (op[1:0] != 2'b11) return e;
    e.rd = rd;
    if (op[5:4] == 2'b00) begin
      e.mem_rd = 1; e.wb_en = 1; e.alu = 4'h1;
    end else if (op[5:4] == 2'b01) begin
      e.wb_en = 1;
      if (op[2]) e.alu = 4'hD;
      else if (fn[2:0] == 3'b101 && fn[3]) e.alu = 4'h9;
      else e.alu = imm_alu[fn[2:0]];
    end else if (op[5:4] == 2'b11) begin
      e.reg_reg = 1; e.wb_en = 1; e.alu = rr_alu[fn];
    end else if (!op[6]) begin
      e.mem_wr = 1; e.alu = 4'h1;
    end else if (op[3]) begin
      e.jump = 1; e.reg_reg = 1; e.wb_en = 1; e.alu = 4'h1;
    end else if (op[2]) begin
      e.jump = 1; e.wb_en = 1; e.alu = 4'h1;
    end else begin
      e.branch = 1; e.alu = br_alu[fn[2:1]];
    end
    if (rd == 0) e.wb_en = 0;
    return e;
  endfunction

  function automatic logic [9:0] ex_of(input exp_t e);
    return {e.valid, e.branch, e.jump, e.reg_reg, e.mem_rd, e.mem_wr, e.alu};
  endfunction

  task automatic model_clear();
    for (int unsigned k = 0; k < PD; k++) m_pipe[k] = '0;
    m_left    = 0;
    m_started = 0;
  endtask

  // One clock: drive at negedge, compare against the model, advance the model, land on the next negedge
  task automatic step(input logic v, input logic [6:0] op, input logic [3:0] fn, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic st, input logic rdr);
    exp_t d;
    bit   legal, use2, dep, open, rdy, hz, acc;
    in_valid = v; in_opcode = op; in_func = fn; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    stall = st; redirect = rdr;
    #1;
    d     = ref_dec(op, fn, rd);
    legal = (op[1:0] == 2'b11);
    use2  = legal && (op[5:4] == 2'b11 || (op[5:4] == 2'b10 && (!op[6] || op[3:2] == 2'b00)));
    dep   = v && m_pipe[0].valid && m_pipe[0].mem_rd && m_pipe[0].rd != 0 &&
            ((legal && m_pipe[0].rd == rs1) || (use2 && m_pipe[0].rd == rs2));
    open  = m_started && m_left == 0 && !st && !rdr;
    rdy   = open && !dep;
    hz    = open && dep;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("hazard", 32'(hazard), 32'(hz));
    chk("ex_ctrl", 32'({ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr, ex_alu_op}),
        32'(ex_of(m_pipe[0])));
    chk("wb_ctrl", 32'({wb_valid, wb_en, wb_rd}),
        32'({m_pipe[PD-1].valid, m_pipe[PD-1].wb_en, m_pipe[PD-1].rd}));
    s_ready  = in_ready;
    s_hazard = hazard;
    acc = v && rdy;
    if (!st) begin
      for (int unsigned k = PD - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = acc ? d : '0;
    end
    if (rdr)                      m_left = FC;
    else if (m_left > 0) begin
      if (!st)                    m_left = m_left - 1;
    end else if (acc && d.jump)   m_left = FC;
    m_started = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, '0, '0, '0, '0, '0, 0, 0);
  endtask

  task automatic do_reset_mid();
    #2 reset = 1'b0;
    #1 chk("rst_async", 32'({ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr, ex_alu_op,
                             wb_valid, wb_en, wb_rd, in_ready, hazard}), 32'd0);
    @(posedge clk);
    #1 chk("rst_hold", 32'({ex_valid, wb_valid, in_ready}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{7'b0110011, 4'b0000, 5'd3,  10'b1_0_0_1_0_0_0001};
    vecs[1]  = '{7'b0110011, 4'b1000, 5'd4,  10'b1_0_0_1_0_0_0010};
    vecs[2]  = '{7'b0110011, 4'b1101, 5'd5,  10'b1_0_0_1_0_0_1001};
    vecs[3]  = '{7'b0110011, 4'b1111, 5'd6,  10'b1_0_0_1_0_0_0000};
    vecs[4]  = '{7'b0000011, 4'b0000, 5'd7,  10'b1_0_0_0_1_0_0001};
    vecs[5]  = '{7'b0000011, 4'b0011, 5'd0,  10'b1_0_0_0_1_0_0001};
    vecs[6]  = '{7'b0100011, 4'b0010, 5'd8,  10'b1_0_0_0_0_1_0001};
    vecs[7]  = '{7'b0010011, 4'b0101, 5'd9,  10'b1_0_0_0_0_0_0111};
    vecs[8]  = '{7'b0010011, 4'b1101, 5'd10, 10'b1_0_0_0_0_0_1001};
    vecs[9]  = '{7'b0010011, 4'b0010, 5'd11, 10'b1_0_0_0_0_0_1010};
    vecs[10] = '{7'b0010111, 4'b0011, 5'd12, 10'b1_0_0_0_0_0_1101};
    vecs[11] = '{7'b1101111, 4'b0000, 5'd1,  10'b1_0_1_1_0_0_0001};
    vecs[12] = '{7'b1100111, 4'b0000, 5'd2,  10'b1_0_1_0_0_0_0001};
    vecs[13] = '{7'b1100011, 4'b0000, 5'd0,  10'b1_1_0_0_0_0_0010};
    vecs[14] = '{7'b1100011, 4'b0110, 5'd0,  10'b1_1_0_0_0_0_1011};
    vecs[15] = '{7'b1100011, 4'b0010, 5'd0,  10'b1_1_0_0_0_0_0000};
    vecs[16] = '{7'b1100011, 4'b0101, 5'd0,  10'b1_1_0_0_0_0_1010};
    vecs[17] = '{7'b0110001, 4'b0000, 5'd13, 10'b1_0_0_0_0_0_0000};
    vecs[18] = '{7'b0010011, 4'b1001, 5'd14, 10'b1_0_0_0_0_0_0110};

    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr, ex_alu_op,
                            wb_valid, wb_en, wb_rd, in_ready, hazard}), 32'd0);
    reset = 1'b1;
    idle(2);

    for (int unsigned i = 0; i < 19; i++) begin
      tries = 0;
      s_ready = 1'b0;
      while (!s_ready && tries < 8) begin
        step(1, vecs[i].op, vecs[i].fn, vecs[i].rd, '0, '0, 0, 0);
        tries++;
      end
      chk("vec_accept", 32'(s_ready), 32'd1);
      chk("vec_decode", 32'({ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr, ex_alu_op}),
          32'(vecs[i].ex));
    end

    // ADD x3: EX next cycle, WB three cycles after acceptance
    idle(4);
    step(1, 7'b0110011, 4'b0000, 5'd3, 5'd1, 5'd2, 0, 0);
    chk("add_accept", 32'(s_ready), 32'd1);
    chk("add_ex", 32'({ex_valid, ex_reg_reg, ex_alu_op}), 32'({1'b1, 1'b1, 4'b0001}));
    idle(2);
    chk("add_wb", 32'({wb_valid, wb_en, wb_rd}), 32'({1'b1, 1'b1, 5'd3}));

    // load x5 then consumer of x5 via rs2
    idle(4);
    step(1, 7'b0000011, 4'b0000, 5'd5, 5'd0, 5'd0, 0, 0);
    step(1, 7'b0110011, 4'b0000, 5'd6, 5'd0, 5'd5, 0, 0);
    chk("lu_hazard", 32'({s_hazard, s_ready}), 32'b10);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    step(1, 7'b0110011, 4'b0000, 5'd6, 5'd0, 5'd5, 0, 0);
    chk("lu_retry", 32'({s_hazard, s_ready}), 32'b01);
    chk("lu_dep_ex", 32'({ex_valid, ex_reg_reg}), 32'b11);

    // JAL opens a FLUSH_CYCLES-long gap in in_ready
    idle(4);
    step(1, 7'b1101111, 4'b0000, 5'd1, 5'd0, 5'd0, 0, 0);
    chk("jal_accept", 32'(s_ready), 32'd1);
    zeros = 0;
    seen  = 0;
    for (int unsigned i = 0; i < 6 && !seen; i++) begin
      idle(1);
      if (s_ready) seen = 1;
      else zeros++;
    end
    chk("jal_flush_len", zeros, FC);
    chk("jal_ready_back", 32'(seen), 32'd1);

    // stall holds a full pipe; redirect mid-stall still enters FLUSH
    idle(4);
    step(1, 7'b0110011, 4'b0000, 5'd1, 5'd0, 5'd0, 0, 0);
    step(1, 7'b0110011, 4'b1000, 5'd2, 5'd0, 5'd0, 0, 0);
    step(1, 7'b0000011, 4'b0000, 5'd3, 5'd0, 5'd0, 0, 0);
    snap_ex = {ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr, ex_alu_op};
    snap_wb = {wb_valid, wb_en, wb_rd};
    for (int unsigned i = 0; i < 3; i++) begin
      step(1, 7'b0110011, 4'b0000, 5'd4, 5'd0, 5'd0, 1, i == 1);
      chk("stall_ex_hold", 32'({ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr, ex_alu_op}),
          32'(snap_ex));
      chk("stall_wb_hold", 32'({wb_valid, wb_en, wb_rd}), 32'(snap_wb));
      chk("stall_ready", 32'(s_ready), 32'd0);
    end
    step(1, 7'b0110011, 4'b0000, 5'd4, 5'd0, 5'd0, 0, 0);
    chk("redir_flush", 32'(s_ready), 32'd0);

    // reset while flushing with valid stages
    idle(4);
    step(1, 7'b0110011, 4'b0000, 5'd3, 5'd0, 5'd0, 0, 0);
    step(1, 7'b1101111, 4'b0000, 5'd7, 5'd0, 5'd0, 0, 0);
    do_reset_mid();
    idle(2);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // opcode 0000000 decodes as an all-zero valid NOP
    idle(4);
    step(1, 7'b0000000, 4'b0000, 5'd5, 5'd0, 5'd0, 0, 0);
    chk("nop_ex", 32'({ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr, ex_alu_op}),
        32'(10'b1000000000));
    idle(2);
    chk("nop_wb", 32'({wb_valid, wb_en, wb_rd}), 32'({1'b1, 1'b0, 5'd0}));

    // randomized traffic against the model
    for (int unsigned i = 0; i < 600; i++) begin
      r_op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 7)];
      step($urandom_range(0, 9) < 8, r_op, 4'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 2, $urandom_range(0, 29) == 0);
      if (i == 300) do_reset_mid();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameter PIPE_DEPTH, default 3, SHALL set the number of registered control stages after decode (EX = stage 1, WB = stage PIPE_DEPTH), legal range 1..4.
REQ-002 Parameter FLUSH_CYCLES, default 2, SHALL set the bubbles inserted after a control transfer, legal range 1..3.
REQ-003 Parameter ALU_OP_W, default 4, SHALL set the alu_op width (minimum 4); the codes listed under Function SHALL be zero-extended to this width.
REQ-004 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  instruction present at decode; in_opcode in 7, in_func in 4, in_rd/in_rs1/in_rs2 in 5 each.
REQ-007 stall  in  1  downstream hold; redirect  in  1  taken branch resolved in EX.
REQ-008 in_ready  out  1  decode accepts this cycle; hazard  out  1  load-use bubble inserted this cycle.
REQ-009 ex_valid, ex_branch, ex_jump, ex_reg_reg, ex_mem_rd, ex_mem_wr  out  1 each; ex_alu_op  out  ALU_OP_W  stage-1 control.
REQ-010 wb_valid, wb_en  out  1 each; wb_rd  out  5  stage-PIPE_DEPTH writeback control.

Function
REQ-011 Decode SHALL produce NOP (all controls 0, alu_op 0000) when opcode[1:0] != 11.
REQ-012 opcode[5:4]=00 (load): mem_rd=1, wb_en=1, alu_op 0001.
REQ-013 opcode[5:4]=01: opcode[2]=1 -> alu_op 1101, wb_en=1; else func[2:0] 000/001/010/011/100/110/111 -> 0001/0110/1010/1011/0011/0100/0101, and 101 -> 0111 if func[3]=0, else 1001; wb_en=1.
REQ-014 opcode[5:4]=10, opcode[6]=0 (store): mem_wr=1, wb_en=0, alu_op 0001.
REQ-015 opcode[5:4]=10, opcode[6]=1: opcode[3]=1 -> JAL (jump=1, reg_reg=1, wb_en=1, alu_op 0001); else opcode[2]=1 -> JALR (jump=1, wb_en=1, alu_op 0001); else branch (branch=1, wb_en=0; func[2:0] 000/001 -> 0010, 100/101 -> 1010, 110/111 -> 1011, 010/011 -> 0000).
REQ-016 opcode[5:4]=11 (reg-reg): reg_reg=1, wb_en=1; func 0000/1000/0001/0010/0011/0100/0101/1101/0110/0111 -> 0001/0010/0110/1010/1011/0011/0111/1001/0100/0101; any other func -> 0000.
REQ-017 wb_en SHALL be forced 0 when rd=0.
REQ-018 Accept = in_valid & in_ready; stage 1 SHALL load decoded control with valid=accept; stage k SHALL load stage k-1 each cycle stall=0; all stages SHALL hold when stall=1.
REQ-019 Load-use: when stage 1 is valid mem_rd with rd!=0 equal to in_rs1 (any non-NOP) or in_rs2 (store, branch, reg-reg), hazard=1, in_ready=0, stage 1 SHALL take a bubble; hazard SHALL last exactly one cycle per occurrence.
REQ-020 FSM states RUN, FLUSH; RUN -> FLUSH on accepted jump or on redirect, loading counter=FLUSH_CYCLES; FLUSH decrements each non-stalled cycle, returns to RUN after the cycle it reaches 1.
REQ-021 in_ready SHALL be 0 in FLUSH, during hazard, during stall, and in the redirect cycle.
REQ-022 redirect SHALL take priority over stall and hazard; redirect during FLUSH SHALL reload the counter.
REQ-023 Latency: an accepted instruction SHALL appear on ex_* next cycle and on wb_* PIPE_DEPTH cycles after acceptance, plus stalled cycles.

Reset
REQ-024 reset low SHALL immediately force state RUN, counter 0, all stage valids and controls 0, alu_op 0, hazard 0, and in_ready 0.
REQ-025 in_ready SHALL go 1 on the first posedge after reset release, including release mid-FLUSH.

Configuration
REQ-026 With CTRL_ILLEGAL_TRAP_EN defined, opcode[1:0] != 11 with in_valid SHALL set output illegal_inst (sticky, cleared only by reset) and enter FLUSH; without it, port illegal_inst SHALL be absent and the case decodes as NOP.

Verification
REQ-027 ADD x3 (opcode 0110011, func 0000, rd 3) accepted at T -> ex_alu_op=0001, ex_reg_reg=1 at T+1; wb_en=1, wb_rd=3 at T+3.
REQ-028 Load rd=5 then reg-reg rs2=5 back-to-back -> hazard=1 one cycle, ex_valid=0 bubble, dependent reaches EX one cycle late.
REQ-029 JAL accepted, FLUSH_CYCLES=2 -> in_ready=0 exactly two cycles, then 1.
REQ-030 stall=1 for 3 cycles with full pipe -> all ex_*/wb_* unchanged; redirect asserted during the stall -> in_ready=0, FLUSH entered.
REQ-031 reset low mid-FLUSH with valid stages -> all outputs 0 asynchronously; in_ready=1 one cycle after release.
REQ-032 opcode 0000000 with in_valid -> NOP without macro; illegal_inst=1 and FLUSH with CTRL_ILLEGAL_TRAP_EN.
